data_memory: RTL
================

Name: data_memory

Overview:
- Data memory (DM) for the single-cycle MIPS datapath, directly downstream of the ALU.
- Consumes the ALU Result as the byte address and the GRF rt value as store data.
- Returns load data, sign/zero-extended, to the GRF write-back mux.
- Supports lw/sw, lh/lhu/sh and lb/lbu/sb.
- Storage is word-organised with per-byte write enables; reads are combinational, writes happen on the clock edge.

Parameters:
- DEPTH_WORDS, 3072, number of 32-bit words (12 KiB; byte addresses 0x0000_0000..0x0000_2FFF).
- IDX_W, 12, word-index width; must satisfy 2^IDX_W >= DEPTH_WORDS.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- pc  input  32  PC of the current instruction (write log only).
- addr  input  32  byte address (ALU Result).
- wdata  input  32  store data (GRF rt); the low bytes are used for sh/sb.
- mem_write  input  1  store enable for this cycle.
- mem_op  input  3  access type: DM_W, DM_H, DM_HU, DM_B, DM_BU.
- rdata  output  32  extended load data, combinational.

Behaviour:
- Word index = addr[IDX_W+1:2]. In range iff addr < DEPTH_WORDS*4, i.e. addr[31:2] < DEPTH_WORDS.
- Alignment: DM_W ignores addr[1:0]; DM_H/DM_HU ignore addr[0]. Misaligned accesses are truncated silently; no exception.
- Byte lanes are little-endian: byte k = bits [8k+7:8k].
- Read path, combinational, zero cycles latency from addr/mem_op to rdata:
  - DM_W: the full word.
  - DM_H: halfword selected by addr[1], sign-extended. DM_HU: same, zero-extended.
  - DM_B: byte selected by addr[1:0], sign-extended. DM_BU: same, zero-extended.
  - Out-of-range address: rdata = 0.
- Write path:
  - On posedge clk with mem_write=1, reset=0 and address in range, the enabled lanes are updated:
    - DM_W: all 4 lanes get wdata.
    - DM_H/DM_HU: 2 lanes (by addr[1]) get wdata[15:0].
    - DM_B/DM_BU: 1 lane (by addr[1:0]) gets wdata[7:0].
  - Unselected lanes keep their value.
  - Out-of-range write: no state change.
  - Undefined mem_op with mem_write=1: no state change; rdata = 0.
- Read-during-write, same cycle: rdata shows the old contents. The new value is visible from the cycle after the edge.
- Reset:
  - On posedge clk with reset=1, every word is cleared to 0 and any simultaneous write is discarded. Reset wins.
  - After reset, rdata = 0 for any address.
  - Reset asserted between two stores: the first store's data is lost; no partial state survives.
- No handshake; single-cycle, always ready.
- Access to the top word (addr 0x2FFC) is legal; 0x3000 is out of range.

Optional Feature:
- Macro DM_WRITE_LOG_EN.
- Defined: on every committed write edge, print "%d@%h: *%h <= %h" with $time, pc, word-aligned address {addr[31:2],2'b00}, and the full merged 32-bit word after the write.
  - The merged word is always printed, even for sb/sh.
  - Nothing is printed for discarded or out-of-range writes, or under reset.
- Undefined: no $display; no functional difference.

Decomposition:
- Shared constants header (existing constants.v) gains DM_W=3'd0, DM_H=3'd1, DM_HU=3'd2, DM_B=3'd3, DM_BU=3'd4, alongside the existing ALU_* codes. The control unit drives mem_op using these names.
- One sub-module: dm_lane_ctrl.
  - Inputs: mem_op and addr[1:0].
  - Outputs: 4-bit byte enable, shifted write word, and load-extension result from the raw read word.
  - Purely combinational; reusable by a later bridge/peripheral stage.

Test Plan:
- reset=1 one cycle, then read DM_W at 0x0, 0x2FFC -> rdata=0x00000000 at both.
- sw 0x12345678 @0x10; next cycle lw 0x10 -> 0x12345678. lbu 0x13 -> 0x00000012. lb 0x11 -> 0x00000056. lhu 0x12 -> 0x00001234.
- Over the stored word: sb 0xAB @0x12 -> word 0x12AB5678. lb 0x12 -> 0xFFFFFFAB. sh 0xBEEF @0x10 -> word 0x12ABBEEF. lh 0x10 -> 0xFFFFBEEF.
- sw 0xDEADBEEF @0x3000 -> no change; read 0x3000 -> 0. sw @0x2FFC then lw 0x2FFC -> 0xDEADBEEF.
- Same-cycle collision: mem_write=1 and reset=1, addr 0x20, data 0x1 -> after edge lw 0x20 = 0. Also check rdata shows the old value during a write cycle.
- DM_WRITE_LOG_EN defined: pc=0x3000, sb 0xFF @0x21 on zeroed memory -> exactly one line "…@00003000: *00000020 <= 0000ff00". No line for the out-of-range store.

Source files
------------

// File: rtl/data_memory_pkg.sv
// Shared memory-access codes and load-extension helper for the data memory.
// DM_* values sit alongside the ALU_* codes driven by the control unit.
package data_memory_pkg;

   typedef enum logic [2:0] {
      DM_W  = 3'd0,
      DM_H  = 3'd1,
      DM_HU = 3'd2,
      DM_B  = 3'd3,
      DM_BU = 3'd4
   } dm_op_e;

   localparam int unsigned DmWordBytes = 4;

   // Extends a halfword or byte (low bits of val) to 32 bits.
   function automatic logic [31:0] load_ext(input logic [15:0] val,
                                            input logic        is_half,
                                            input logic        sign);
      logic [31:0] res;
      if (is_half) begin
         res = {{16{sign & val[15]}}, val};
      end else begin
         res = {{24{sign & val[7]}}, val[7:0]};
      end
      return res;
   endfunction

endpackage

// File: rtl/data_memory_if.sv
// Bus between the datapath (master) and the data memory (slave).
// Signals are sampled combinationally; there is no handshake.
interface data_memory_if;

   logic [31:0] pc;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        mem_write;
   logic [2:0]  mem_op;
   logic [31:0] rdata;

   modport master (
      output pc,
      output addr,
      output wdata,
      output mem_write,
      output mem_op,
      input  rdata
   );

   modport slave (
      input  pc,
      input  addr,
      input  wdata,
      input  mem_write,
      input  mem_op,
      output rdata
   );

endinterface

// File: rtl/dm_lane_ctrl.sv
// Byte-lane steering for word-organised memory: byte enables, replicated store
// data and load extension. Purely combinational.
module dm_lane_ctrl
   import data_memory_pkg::*;
(
   input  logic [2:0]  mem_op_i,
   input  logic [1:0]  addr_lo_i,
   input  logic [31:0] wdata_i,
   input  logic [31:0] rword_i,
   output logic [3:0]  byte_en_o,
   output logic [31:0] wword_o,
   output logic [31:0] rdata_o,
   output logic        op_valid_o
);

   logic [15:0] half_sel;
   logic [7:0]  byte_sel;

   assign half_sel = addr_lo_i[1] ? rword_i[31:16] : rword_i[15:0];
   assign byte_sel = rword_i[{addr_lo_i, 3'b000} +: 8];

   always_comb begin
      byte_en_o  = 4'b0000;
      wword_o    = '0;
      rdata_o    = '0;
      op_valid_o = 1'b1;
      case (mem_op_i)
         DM_W: begin
            byte_en_o = 4'b1111;
            wword_o   = wdata_i;
            rdata_o   = rword_i;
         end
         DM_H, DM_HU: begin
            byte_en_o = addr_lo_i[1] ? 4'b1100 : 4'b0011;
            wword_o   = {2{wdata_i[15:0]}};
            rdata_o   = load_ext(half_sel, 1'b1, mem_op_i == DM_H);
         end
         DM_B, DM_BU: begin
            byte_en_o = 4'b0001 << addr_lo_i;
            wword_o   = {4{wdata_i[7:0]}};
            rdata_o   = load_ext({8'h00, byte_sel}, 1'b0, mem_op_i == DM_B);
         end
         default: begin
            op_valid_o = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/data_memory.sv
// Word-organised data memory with byte enables, combinational reads and clocked writes.
// Optional write log enabled by defining DM_WRITE_LOG_EN.
module data_memory
   import data_memory_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = 3072,
   parameter int unsigned IDX_W       = 12
) (
   input  logic          clk,
   input  logic          reset,
   data_memory_if.slave  bus
);

   if ((64'd1 << IDX_W) < 64'(DEPTH_WORDS)) begin : g_bad_idx_w
      $error("IDX_W too small for DEPTH_WORDS");
   end

   logic [31:0]      mem_q [DEPTH_WORDS];

   logic             in_range;
   logic [IDX_W-1:0] idx;
   logic [31:0]      raw_word;
   logic [31:0]      merged_word;
   logic [31:0]      lane_rdata;
   logic [31:0]      lane_wword;
   logic [3:0]       byte_en;
   logic             op_valid;
   logic             write_en;

   // Upper address bits must be checked too, otherwise high addresses alias low words.
   assign in_range = ({2'b00, bus.addr[31:2]} < DEPTH_WORDS);
   assign idx      = bus.addr[IDX_W+1:2];
   assign raw_word = in_range ? mem_q[idx] : '0;

   dm_lane_ctrl u_lane_ctrl (
      .mem_op_i   (bus.mem_op),
      .addr_lo_i  (bus.addr[1:0]),
      .wdata_i    (bus.wdata),
      .rword_i    (raw_word),
      .byte_en_o  (byte_en),
      .wword_o    (lane_wword),
      .rdata_o    (lane_rdata),
      .op_valid_o (op_valid)
   );

   always_comb begin
      merged_word = raw_word;
      for (int unsigned k = 0; k < DmWordBytes; k++) begin
         if (byte_en[k]) begin
            merged_word[8*k +: 8] = lane_wword[8*k +: 8];
         end
      end
   end

   assign write_en = bus.mem_write & in_range & op_valid;
   assign bus.rdata = in_range ? lane_rdata : '0;

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned i = 0; i < DEPTH_WORDS; i++) begin
            mem_q[i] <= '0;
         end
      end else if (write_en) begin
         mem_q[idx] <= merged_word;
      end
   end

`ifdef DM_WRITE_LOG_EN
   always_ff @(posedge clk) begin
      if (!reset && write_en) begin
         $display("%d@%h: *%h <= %h", $time, bus.pc, {bus.addr[31:2], 2'b00}, merged_word);
      end
   end
`else
   logic [31:0] unused_pc;
   assign unused_pc = bus.pc;
`endif

endmodule
